mux_share_arbiter: RTL
======================

# mux_share_arbiter

Round-robin arbiter and sequencer that shares one single-bit 2:1-MUX-based logic unit (e.g. the MUX-built OR gate) among NUM_REQ requesters. It selects one requester at a time, steers that requester's operand pair onto the shared unit's `a`/`b` inputs, and returns the unit's `y` as a registered, per-requester-qualified result. It sits between the requester-side logic and the shared gate instance, and is the only block that drives that instance.

## Interface
- `NUM_REQ`, default 4: number of requesters; legal range 2..16.
- `HOLD_MAX`, default 4: maximum consecutive grant cycles while another requester waits; legal range ≥1.
- `clk`, input, 1: rising-edge clock.
- `rst_n`, input, 1: asynchronous, active-low reset.
- `req`, input, NUM_REQ: request per requester; held high while the requester wants the unit.
- `a_in`, input, NUM_REQ: operand A per requester.
- `b_in`, input, NUM_REQ: operand B per requester.
- `gnt`, output, NUM_REQ: one-hot grant, registered; all-zero when idle.
- `unit_a`, output, 1: operand A to the shared unit.
- `unit_b`, output, 1: operand B to the shared unit.
- `unit_y`, input, 1: combinational result from the shared unit.
- `res_data`, output, 1: registered `unit_y`.
- `res_valid`, output, NUM_REQ: one-hot; marks the owner of `res_data`.

## Operation
- States: IDLE, BUSY, GAP.
- IDLE: if any `req` is high, select the first set bit at or after `ptr`, wrapping modulo NUM_REQ. Register `gnt` to that one-hot, set `hold_cnt`=1, go to BUSY. Otherwise stay in IDLE.
- BUSY, with granted index g:
  - `unit_a`=`a_in[g]`, `unit_b`=`b_in[g]`.
  - Each cycle, register `res_data`<=`unit_y` and `res_valid`<=`gnt`.
- BUSY exit conditions:
  - `req[g]`=0: go to GAP.
  - `hold_cnt`==HOLD_MAX and any other `req` is high: go to GAP (forced rotation).
  - `hold_cnt`==HOLD_MAX and no other `req` is high: stay in BUSY, reload `hold_cnt`=1.
  - Otherwise: `hold_cnt`++.
- On entering GAP: `gnt`<=0 and `ptr`<=(g+1) mod NUM_REQ.
- GAP lasts exactly one cycle, during which the shared MUX selects settle. It then arbitrates exactly as IDLE does: go to BUSY if any `req`, else IDLE.
- `unit_a`/`unit_b` are combinational from `gnt` and are 0 whenever `gnt`==0.
- `hold_cnt` is $clog2(HOLD_MAX+1) bits wide and never exceeds HOLD_MAX.
- Requests are level-sensitive; a requester that drops `req` loses its turn with no memory of it.

## Timing
- Reset values (applied asynchronously on `rst_n` low): state=IDLE, `ptr`=0, `hold_cnt`=0, `gnt`=0, `res_valid`=0, `res_data`=0, `unit_a`=`unit_b`=0.
- Reset mid-grant clears everything immediately; the next grant after reset starts the search from requester 0.
- Request-to-grant latency from IDLE: `req` high before edge n gives `gnt` high after edge n.
- Grant-to-result latency: `res_valid` follows `gnt` by one cycle. `res_data` at cycle k+1 equals the unit result for the operands presented at cycle k.
- Handover cost: one dead GAP cycle between any two grants. `res_valid` is therefore all-zero for one cycle, one cycle after the grant drops.
- Operand changes on `a_in[g]`/`b_in[g]` during BUSY are propagated every cycle; there is no operand latching.
- Simultaneous drop of `req[g]` and a new `req[j]`: GAP first, then grant j.
- Simultaneous requests in IDLE: the lowest index at or after `ptr` wins.
- A non-granted `req` pulse shorter than the time to its turn is lost.

## Structure
- Package `mux_share_pkg` holds:
  - state enum `arb_state_t` {IDLE, BUSY, GAP};
  - default constants for NUM_REQ and HOLD_MAX;
  - a function returning the counter width.
- Sub-module `rr_pick`: combinational round-robin selector. Inputs `req` and `ptr`; outputs a one-hot grant and an `any` flag. It is reused for IDLE and GAP arbitration.
- The top level holds the FSM, `hold_cnt`, `ptr`, the operand MUX and the result registers.

## Test plan
- Reset: assert `rst_n`=0 mid-BUSY -> all outputs 0 immediately; after release, `req`=4'b1000 -> `gnt`=4'b1000 one cycle later.
- Single requester, OR unit: `req`=4'b0010; drive `a_in[1]`/`b_in[1]` through 00, 01, 10, 11 on consecutive cycles -> `res_data` 0,1,1,1 with `res_valid`=4'b0010, each one cycle after its operands.
- Contention: `req`=4'b1111 held, HOLD_MAX=4 -> grants 0,1,2,3,0, each lasting 4 cycles and separated by a one-cycle GAP with `gnt`=0.
- Sole long holder: `req`=4'b0100 held for 20 cycles -> `gnt` stays 4'b0100 with no GAP; `hold_cnt` cycles 1..4.
- Early release: grant 0 active, drop `req[0]` at its cycle 2 while `req[3]` is high -> GAP, then `gnt`=4'b1000, `ptr`=1 before the handover.
- Wrap-around: after serving requester 3, `req`=4'b1001 -> requester 0 is granted, not 3.

Source files
------------

// File: rtl/mux_share_pkg.sv
// Shared definitions for the MUX-unit sharing arbiter.
//   arb_state_t    : arbiter FSM states
//   DEF_NUM_REQ    : default number of requesters
//   DEF_HOLD_MAX   : default maximum consecutive grant cycles under contention
//   cnt_width()    : width of the hold counter for a given HOLD_MAX
package mux_share_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } arb_state_t;

    localparam int DEF_NUM_REQ  = 4;
    localparam int DEF_HOLD_MAX = 4;

    // Counter must represent 0..hold_max inclusive.
    function automatic int cnt_width(input int hold_max);
        return $clog2(hold_max + 1);
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin selector.
//   req : request vector, one bit per requester
//   ptr : index where the search starts (wraps modulo NUM_REQ)
//   gnt : one-hot selection of the first set request at or after ptr
//   any : high when at least one request is set
module rr_pick #(
    parameter int NUM_REQ = 4,
    parameter int PTR_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PTR_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic               any
);

    // Two passes: first the indices at or above ptr, then the wrapped
    // indices below ptr. The first hit in that order wins.
    always_comb begin
        gnt = '0;
        any = 1'b0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (i >= int'(ptr))) begin
                gnt[i] = 1'b1;
                any    = 1'b1;
            end
        end
        for (int i = 0; i < NUM_REQ; i++) begin
            if (!any && req[i] && (i < int'(ptr))) begin
                gnt[i] = 1'b1;
                any    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mux_share_arbiter.sv
// Round-robin arbiter/sequencer sharing one single-bit MUX-built logic unit
// among NUM_REQ requesters.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : per-requester request (level)
//   a_in, b_in : per-requester operands
//   gnt        : registered one-hot grant, zero when idle or in the gap cycle
//   unit_a/b   : operands steered to the shared unit (zero when no grant)
//   unit_y     : combinational result from the shared unit
//   res_data   : registered unit_y
//   res_valid  : registered grant, marks the owner of res_data
module mux_share_arbiter
    import mux_share_pkg::*;
#(
    parameter int NUM_REQ  = DEF_NUM_REQ,
    parameter int HOLD_MAX = DEF_HOLD_MAX
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NUM_REQ-1:0] req,
    input  logic [NUM_REQ-1:0] a_in,
    input  logic [NUM_REQ-1:0] b_in,
    output logic [NUM_REQ-1:0] gnt,
    output logic               unit_a,
    output logic               unit_b,
    input  logic               unit_y,
    output logic               res_data,
    output logic [NUM_REQ-1:0] res_valid
);

    localparam int PTR_W = $clog2(NUM_REQ);
    localparam int CNT_W = cnt_width(HOLD_MAX);

    arb_state_t         state;
    logic [PTR_W-1:0]   ptr;
    logic [CNT_W-1:0]   hold_cnt;

    logic [NUM_REQ-1:0] pick_gnt;
    logic               pick_any;
    logic [PTR_W-1:0]   gidx;
    logic [PTR_W-1:0]   ptr_next;
    logic               owner_req;
    logic               others_req;
    logic               at_max;

    rr_pick #(
        .NUM_REQ (NUM_REQ),
        .PTR_W   (PTR_W)
    ) u_pick (
        .req (req),
        .ptr (ptr),
        .gnt (pick_gnt),
        .any (pick_any)
    );

    // Operand steering: AND-OR over the one-hot grant, so a zero grant
    // forces both operands low.
    assign unit_a = |(a_in & gnt);
    assign unit_b = |(b_in & gnt);

    // Index of the current owner, used to advance the pointer past it.
    always_comb begin
        gidx = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (gnt[i]) begin
                gidx = PTR_W'(i);
            end
        end
    end

    assign ptr_next   = (gidx == PTR_W'(NUM_REQ - 1)) ? '0 : gidx + PTR_W'(1);
    assign owner_req  = |(req & gnt);
    assign others_req = |(req & ~gnt);
    assign at_max     = (hold_cnt == CNT_W'(HOLD_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            hold_cnt  <= '0;
            gnt       <= '0;
            res_valid <= '0;
            res_data  <= 1'b0;
        end else begin
            // Result stage: one cycle behind the grant/operand stage.
            res_valid <= gnt;
            res_data  <= (state == BUSY) ? unit_y : 1'b0;

            case (state)
                IDLE, GAP: begin
                    if (pick_any) begin
                        gnt      <= pick_gnt;
                        hold_cnt <= CNT_W'(1);
                        state    <= BUSY;
                    end else begin
                        state    <= IDLE;
                    end
                end
                BUSY: begin
                    if (!owner_req || (at_max && others_req)) begin
                        // Release: one dead cycle lets the shared MUX selects settle.
                        gnt      <= '0;
                        ptr      <= ptr_next;
                        hold_cnt <= '0;
                        state    <= GAP;
                    end else if (at_max) begin
                        // Nobody else waiting: keep the grant, restart the budget.
                        hold_cnt <= CNT_W'(1);
                    end else begin
                        hold_cnt <= hold_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    gnt      <= '0;
                    hold_cnt <= '0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule
